// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory bank.
// Holds the access-size encodings, the FSM state type and the byte-enable helper
// used for both the store lane mask and the word-crossing test.
package data_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  typedef enum logic {StIdle, StSplit} mem_state_e;

  // Byte-enable mask across two consecutive words: bits [3:0] are the lanes of
  // word N, bits [7:4] the lanes of word N+1. An illegal size yields no lanes.
  function automatic logic [7:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    logic [7:0] mask;
    case (size)
      SZ_BYTE: mask = 8'b0000_0001;
      SZ_HALF: mask = 8'b0000_0011;
      SZ_WORD: mask = 8'b0000_1111;
      default: mask = 8'b0000_0000;
    endcase
    return mask << off;
  endfunction

endpackage

// File: rtl/load_extend_unit.sv
// Combinational load extension.
// Ports:
//   raw_i      : right-aligned load bytes
//   size_i     : access size (byte/half/word)
//   unsigned_i : zero-extend when 1, sign-extend when 0 (ignored for words)
//   data_o     : extended 32-bit load result
module load_extend_unit
  import data_mem_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = raw_i;
    case (size_i)
      SZ_BYTE: data_o = {{24{raw_i[7] & ~unsigned_i}}, raw_i[7:0]};
      SZ_HALF: data_o = {{16{raw_i[15] & ~unsigned_i}}, raw_i[15:0]};
      default: data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/data_memory_bank.sv
// Byte-addressable, word-organised data memory with byte/half/word access.
// Word-crossing accesses are split over two cycles (IDLE -> SPLIT -> IDLE).
// Ports:
//   clk_i, rst_n_i   : clock, asynchronous active-low reset
//   req_i, we_i      : request, store(1)/load(0)
//   size_i           : 0 byte, 1 half, 2 word, 3 illegal
//   unsigned_i       : zero-extend loads
//   addr_i, wdata_i  : byte address, store data
//   ready_o          : request can be accepted
//   rvalid_o,rdata_o : load completion pulse and extended data
//   err_o            : fault pulse, err_count_o: saturating fault count
module data_memory_bank
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned ADDR_W      = 32,
  parameter bit          SPLIT_EN    = 1'b1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              ready_o,
  output logic              rvalid_o,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  err_count_o
);

  localparam int unsigned IdxW  = $clog2(DEPTH_WORDS);
  localparam int unsigned WIdxW = ADDR_W - 2;
  localparam int unsigned ExtW  = WIdxW + 1;
  localparam logic [ExtW-1:0] DepthLim = ExtW'(DEPTH_WORDS);
  localparam logic [ExtW-1:0] ExtOne   = ExtW'(1);

  logic [31:0] mem_q [DEPTH_WORDS];

  mem_state_e      state_q, state_d;
  logic [IdxW-1:0] nidx_q, nidx_d;
  logic [1:0]      off_q, off_d, size_q, size_d;
  logic            uns_q, uns_d, we_q, we_d;
  logic [3:0]      be_hi_q, be_hi_d;
  logic [31:0]     whi_q, whi_d, lo_q, lo_d;
  logic            rvalid_q, rvalid_d, err_q, err_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [ExtW-1:0] idx_ext;
  logic [IdxW-1:0] idx_lo, rd_idx, wr_idx;
  logic [1:0]      off;
  logic [7:0]      be;
  logic [63:0]     wsh;
  logic            crosses, fault;
  logic [31:0]     rd_word, wr_data, ext_raw, ext_data;
  logic [3:0]      wr_be;
  logic            wr_en;
  logic [1:0]      ext_size;
  logic            ext_uns;

  assign idx_ext = {1'b0, addr_i[ADDR_W-1:2]};
  assign idx_lo  = addr_i[IdxW+1:2];
  assign off     = addr_i[1:0];
  assign be      = byte_en(size_i, off);
  assign wsh     = {32'b0, wdata_i} << {off, 3'b000};
  assign crosses = |be[7:4];
  assign fault   = (size_i == SZ_ILL) || (idx_ext >= DepthLim) ||
                   (crosses && ((idx_ext + ExtOne) >= DepthLim)) ||
                   (crosses && !SPLIT_EN);

  // In SPLIT the read port serves word N+1; otherwise the addressed word N.
  assign rd_idx  = (state_q == StSplit) ? nidx_q : idx_lo;
  assign rd_word = mem_q[rd_idx];

  always_comb begin
    if (state_q == StSplit) begin
      ext_raw  = 32'({rd_word, lo_q} >> {off_q, 3'b000});
      ext_size = size_q;
      ext_uns  = uns_q;
    end else begin
      ext_raw  = rd_word >> {off, 3'b000};
      ext_size = size_i;
      ext_uns  = unsigned_i;
    end
  end

  load_extend_unit u_load_extend (
    .raw_i      (ext_raw),
    .size_i     (ext_size),
    .unsigned_i (ext_uns),
    .data_o     (ext_data)
  );

  always_comb begin
    state_d  = state_q;
    nidx_d   = nidx_q;
    off_d    = off_q;
    size_d   = size_q;
    uns_d    = uns_q;
    we_d     = we_q;
    be_hi_d  = be_hi_q;
    whi_d    = whi_q;
    lo_d     = lo_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    wr_en    = 1'b0;
    wr_idx   = idx_lo;
    wr_be    = 4'b0000;
    wr_data  = wsh[31:0];
    case (state_q)
      StIdle: begin
        if (req_i) begin
          if (fault) begin
            // Faults never enter SPLIT; they complete one cycle after acceptance.
            err_d    = 1'b1;
            rvalid_d = !we_i;
            if (!we_i) rdata_d = '0;
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
          end else begin
            if (we_i) begin
              wr_en = 1'b1;
              wr_be = be[3:0];
            end
            if (crosses) begin
              state_d = StSplit;
              nidx_d  = idx_lo + IdxW'(1);
              off_d   = off;
              size_d  = size_i;
              uns_d   = unsigned_i;
              we_d    = we_i;
              be_hi_d = be[7:4];
              whi_d   = wsh[63:32];
              lo_d    = rd_word;
            end else if (!we_i) begin
              rvalid_d = 1'b1;
              rdata_d  = ext_data;
            end
          end
        end
      end
      StSplit: begin
        state_d = StIdle;
        if (we_q) begin
          wr_en   = 1'b1;
          wr_idx  = nidx_q;
          wr_be   = be_hi_q;
          wr_data = whi_q;
        end else begin
          rvalid_d = 1'b1;
          rdata_d  = ext_data;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= StIdle;
      nidx_q   <= '0;
      off_q    <= '0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      we_q     <= 1'b0;
      be_hi_q  <= '0;
      whi_q    <= '0;
      lo_q     <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      nidx_q   <= nidx_d;
      off_q    <= off_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      we_q     <= we_d;
      be_hi_q  <= be_hi_d;
      whi_q    <= whi_d;
      lo_q     <= lo_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign ready_o     = (state_q == StIdle);
  assign rvalid_o    = rvalid_q;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;
  assign err_count_o = cnt_q;

endmodule

// File: tb/tb_data_memory_bank.sv
// Directed bench for data_memory_bank: instance A splits crossing accesses,
// instance B (SPLIT_EN=0) faults them. Expected load results go into a queue
// when a load is issued and are popped when rvalid is observed.
module tb_data_memory_bank;
  import data_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_a, req_b, we, uns;
  logic [1:0]  sz;
  logic [31:0] addr, wdata;
  logic        ready_a, rvalid_a, err_a, ready_b, rvalid_b, err_b;
  logic [31:0] rdata_a, rdata_b;
  logic [15:0] cnt_a, cnt_b;

  typedef struct packed {logic [31:0] data; logic err;} exp_t;
  exp_t sb_q[$];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  data_memory_bank #(
    .DEPTH_WORDS(256), .ADDR_W(32), .SPLIT_EN(1'b1), .CNT_W(16)
  ) u_dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req_a), .we_i(we), .size_i(sz),
    .unsigned_i(uns), .addr_i(addr), .wdata_i(wdata), .ready_o(ready_a),
    .rvalid_o(rvalid_a), .rdata_o(rdata_a), .err_o(err_a), .err_count_o(cnt_a)
  );

  data_memory_bank #(
    .DEPTH_WORDS(256), .ADDR_W(32), .SPLIT_EN(1'b0), .CNT_W(16)
  ) u_dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req_b), .we_i(we), .size_i(sz),
    .unsigned_i(uns), .addr_i(addr), .wdata_i(wdata), .ready_o(ready_b),
    .rvalid_o(rvalid_b), .rdata_o(rdata_b), .err_o(err_b), .err_count_o(cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one request; returns 1 time unit after the accepting edge.
  task automatic drive(input bit sel, input bit w, input logic [1:0] s, input bit u,
                       input logic [31:0] a, input logic [31:0] d);
    we = w; sz = s; uns = u; addr = a; wdata = d;
    req_a = !sel; req_b = sel;
    @(posedge clk); #1;
    req_a = 1'b0; req_b = 1'b0;
  endtask

  task automatic store(input bit sel, input logic [1:0] s, input logic [31:0] a,
                       input logic [31:0] d);
    drive(sel, 1'b1, s, 1'b0, a, d);
    if (!(sel ? ready_b : ready_a)) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic load_chk(input string tag, input bit sel, input logic [1:0] s, input bit u,
                          input logic [31:0] a, input logic [31:0] exp_data,
                          input bit exp_err, input int exp_lat);
    exp_t e;
    int   lat;
    logic rv;
    sb_q.push_back('{data: exp_data, err: exp_err});
    drive(sel, 1'b0, s, u, a, 32'h0);
    lat = 1;
    rv  = sel ? rvalid_b : rvalid_a;
    while (!rv && lat < 4) begin
      @(posedge clk); #1;
      lat++;
      rv = sel ? rvalid_b : rvalid_a;
    end
    chk({tag, "_rvalid"}, 32'(rv), 32'h1);
    chk({tag, "_lat"}, lat, exp_lat);
    e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    chk({tag, "_data"}, sel ? rdata_b : rdata_a, e.data);
    chk({tag, "_err"}, 32'(sel ? err_b : err_a), 32'(e.err));
  endtask

  initial begin
    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; we = 1'b0; uns = 1'b0;
    sz = SZ_WORD; addr = '0; wdata = '0;
    #3;
    chk("rst_ready", 32'(ready_a), 32'h1);
    chk("rst_rvalid", 32'(rvalid_a), 32'h0);
    chk("rst_rdata", rdata_a, 32'h0);
    chk("rst_err", 32'(err_a), 32'h0);
    chk("rst_cnt", 32'(cnt_a), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Word store, then byte loads signed and unsigned.
    store(0, SZ_WORD, 32'h10, 32'hDEADBEEF);
    chk("wst_ready", 32'(ready_a), 32'h1);
    load_chk("lb_13", 0, SZ_BYTE, 0, 32'h13, 32'hFFFFFFDE, 0, 1);
    load_chk("lbu_13", 0, SZ_BYTE, 1, 32'h13, 32'h000000DE, 0, 1);
    load_chk("lh_12", 0, SZ_HALF, 0, 32'h12, 32'hFFFFDEAD, 0, 1);

    // Half store at offset 1 is single-cycle and preserves lanes 0 and 3.
    store(0, SZ_WORD, 32'h20, 32'h55667788);
    drive(0, 1, SZ_HALF, 0, 32'h21, 32'h00001234);
    chk("sh21_ready", 32'(ready_a), 32'h1);
    load_chk("lw_20", 0, SZ_WORD, 0, 32'h20, 32'h55123488, 0, 1);
    load_chk("lhu_21", 0, SZ_HALF, 1, 32'h21, 32'h00001234, 0, 1);

    // Crossing word store at 0x0E.
    store(0, SZ_WORD, 32'h00, 32'hCAFEF00D);
    store(0, SZ_WORD, 32'h0C, 32'h11112222);
    drive(0, 1, SZ_WORD, 0, 32'h0E, 32'hA1B2C3D4);
    chk("xst_ready_low", 32'(ready_a), 32'h0);
    @(posedge clk); #1;
    chk("xst_ready_back", 32'(ready_a), 32'h1);
    load_chk("lw_0e", 0, SZ_WORD, 0, 32'h0E, 32'hA1B2C3D4, 0, 2);
    load_chk("lw_0c", 0, SZ_WORD, 0, 32'h0C, 32'hC3D42222, 0, 1);
    load_chk("lw_10", 0, SZ_WORD, 0, 32'h10, 32'hDEADA1B2, 0, 1);
    chk("cnt_clean", 32'(cnt_a), 32'h0);

    // Faults on instance A.
    drive(0, 1, SZ_WORD, 0, 32'h400, 32'h12345678);
    chk("oor_st_err", 32'(err_a), 32'h1);
    chk("oor_st_cnt", 32'(cnt_a), 32'h1);
    load_chk("lw_3fd_flt", 0, SZ_WORD, 0, 32'h3FD, 32'h0, 1, 1);
    chk("x_last_cnt", 32'(cnt_a), 32'h2);
    load_chk("ill_flt", 0, SZ_ILL, 0, 32'h10, 32'h0, 1, 1);
    chk("ill_cnt", 32'(cnt_a), 32'h3);
    load_chk("lw_00_kept", 0, SZ_WORD, 0, 32'h00, 32'hCAFEF00D, 0, 1);

    // SPLIT_EN=0: crossing accesses fault without touching memory.
    store(1, SZ_WORD, 32'h00, 32'h01020304);
    store(1, SZ_WORD, 32'h04, 32'h05060708);
    load_chk("b_lh_03_flt", 1, SZ_HALF, 0, 32'h03, 32'h0, 1, 1);
    drive(1, 1, SZ_HALF, 0, 32'h03, 32'h0000FFFF);
    chk("b_sh_03_err", 32'(err_b), 32'h1);
    load_chk("b_lw_00", 1, SZ_WORD, 0, 32'h00, 32'h01020304, 0, 1);
    load_chk("b_lw_04", 1, SZ_WORD, 0, 32'h04, 32'h05060708, 0, 1);
    chk("b_cnt", 32'(cnt_b), 32'h2);

    // Reset in the middle of a split store.
    store(0, SZ_WORD, 32'h40, 32'h0);
    store(0, SZ_WORD, 32'h44, 32'h0);
    drive(0, 1, SZ_WORD, 0, 32'h42, 32'h11223344);
    chk("split_ready_low", 32'(ready_a), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(ready_a), 32'h1);
    chk("mid_rst_rvalid", 32'(rvalid_a), 32'h0);
    chk("mid_rst_rdata", rdata_a, 32'h0);
    chk("mid_rst_cnt", 32'(cnt_a), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    load_chk("rst_lw_40", 0, SZ_WORD, 0, 32'h40, 32'h33440000, 0, 1);
    load_chk("rst_lw_44", 0, SZ_WORD, 0, 32'h44, 32'h00000000, 0, 1);

    // Counter saturation: 0x10000 illegal-size requests back to back.
    we = 1'b1; sz = SZ_ILL; addr = 32'h0; req_a = 1'b1;
    repeat (32'h10000) @(posedge clk);
    #1 req_a = 1'b0;
    chk("sat_err", 32'(err_a), 32'h1);
    chk("sat_cnt", 32'(cnt_a), 32'h0000FFFF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_memory_bank.md
Name: data_memory_bank

Overview:
- Parametrised, word-organised, byte-addressable data memory for the RISC-V datapath.
- Supports byte, half and word loads and stores, with sign- or zero-extension on loads.
- Accesses that cross a word boundary are split into two internal cycles by a small FSM.
- Reports out-of-range and illegal-size accesses through an error pulse and a saturating error counter.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words stored. Power of two, at least 2.
- ADDR_W, 32: byte-address width.
- SPLIT_EN, 1: 1 splits word-crossing accesses into two cycles; 0 makes them fault.
- CNT_W, 16: width of the error counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- req_i  in  1  access request.
- we_i  in  1  1 = store, 0 = load.
- size_i  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- unsigned_i  in  1  load zero-extends when 1.
- addr_i  in  ADDR_W  byte address.
- wdata_i  in  32  store data, low bytes used for byte/half.
- ready_o  out  1  bank can accept a request this cycle.
- rvalid_o  out  1  load data (or load fault) valid, one-cycle pulse.
- rdata_o  out  32  extended load data.
- err_o  out  1  fault pulse for the completing access.
- err_count_o  out  CNT_W  saturating fault count.

Behaviour:
- Reset (async assert, sync release):
  - ready_o=1, rvalid_o=0, rdata_o=0, err_o=0, err_count_o=0, FSM=IDLE.
  - Memory array is not cleared.
- Acceptance: a request is accepted when req_i && ready_o at a rising edge. All inputs are sampled at acceptance only.
- Addressing: word index = addr_i[ADDR_W-1:2]; byte offset = addr_i[1:0].
- Span of an access: end byte = offset + (1 << size) - 1. The access crosses a word boundary when end byte > 3.
  - Half at offset 1 does not cross; it is serviced in one cycle.
  - Half at offset 3 and word at offsets 1-3 cross.
- Fault check, all at acceptance:
  - size_i==3;
  - word index >= DEPTH_WORDS;
  - access crosses and word index+1 >= DEPTH_WORDS;
  - access crosses and SPLIT_EN==0.
- On a fault: no byte is written. err_o pulses in the cycle the access would complete. Loads also pulse rvalid_o with rdata_o=0. err_count_o increments and saturates at all-ones.
- FSM states IDLE and SPLIT:
  - IDLE, non-crossing access: single cycle.
    - Store: enabled byte lanes are written at the accepting edge.
    - Load: rvalid_o and rdata_o are asserted the cycle after acceptance (latency 1).
    - ready_o stays 1.
  - IDLE, crossing access: go to SPLIT; ready_o=0 for exactly one cycle.
    - First edge: lanes offset..3 of word N are accessed.
    - Second edge: lanes 0..end-4 of word N+1 are accessed, then return to IDLE.
    - Load: rvalid_o is asserted 2 cycles after acceptance, with low bytes taken from word N and high bytes from word N+1.
- Store lanes: byte b of wdata_i goes to address addr+b, little-endian. Lanes not enabled are preserved.
- Load extension:
  - Byte: bit 7 replicated, or zeros when unsigned_i=1.
  - Half: bit 15 replicated, or zeros when unsigned_i=1.
  - Word: no extension; unsigned_i is ignored.
- rdata_o holds its last value when rvalid_o=0.
- Back-to-back: a load accepted the cycle after a store to the same bytes returns the new data.
- Reset during SPLIT: FSM returns to IDLE and any pending rvalid_o is dropped. A first-half store already committed remains in memory; the second half is not written.
- Error counter: fault-free accesses never touch it.

Decomposition:
- Package data_mem_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - FSM state typedef (IDLE, SPLIT);
  - byte-enable generation function.
- Sub-module load_extend_unit: combinational. It takes the assembled 32-bit raw data, size and unsigned flag, and produces extended rdata.

Test Plan:
- Word store 0xDEADBEEF at addr 0x10, then byte load at addr 0x13 -> rvalid_o 1 cycle later, rdata_o=0xFFFFFFDE. With unsigned_i=1, rdata_o=0x000000DE.
- Half store 0x1234 at addr 0x21, then word load at addr 0x20 -> bytes 1-2 = 0x1234, bytes 0 and 3 unchanged. Single-cycle, ready_o stays 1.
- Word store 0xA1B2C3D4 at addr 0x0E (crossing) -> ready_o low 1 cycle. Word load at 0x0E -> rvalid_o 2 cycles after acceptance, rdata_o=0xA1B2C3D4. Word load at 0x0C has bytes 2-3 = 0xC3D4.
- Store at word index DEPTH_WORDS -> err_o pulse, no write, err_count_o=1. A crossing word at the last word also faults. size_i=3 faults. Drive 0x10000 faults with CNT_W=16 -> counter holds 0xFFFF.
- SPLIT_EN=0, half load at addr 0x03 -> rvalid_o and err_o together 1 cycle after acceptance, rdata_o=0, memory unchanged.
- Assert rst_n_i during SPLIT of a crossing store -> outputs at reset values immediately. Word N lanes written, word N+1 unchanged. Next request accepted after release.
